// File: rtl/vec_math_pkg.sv
// rtl/vec_math_pkg.sv - shared op/state encodings and step counts for vec3_alu
package vec_math_pkg;

  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_SUB   = 3'd1,
    OP_DOT   = 3'd2,
    OP_CROSS = 3'd3,
    OP_SCALE = 3'd4
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam logic [2:0] STEPS_DOT   = 3'd3;
  localparam logic [2:0] STEPS_SCALE = 3'd3;
  localparam logic [2:0] STEPS_CROSS = 3'd6;

  function automatic logic is_product_op(input logic [2:0] op);
    return (op == OP_DOT) || (op == OP_CROSS) || (op == OP_SCALE);
  endfunction

  function automatic logic is_illegal_op(input logic [2:0] op);
    return op > OP_SCALE;
  endfunction

endpackage

// File: rtl/vec_round_sat.sv
// rtl/vec_round_sat.sv - wide accumulator to D_BITS lane: round, shift, clamp or wrap, overflow flag
module vec_round_sat #(
  parameter int D_BITS   = 32,
  parameter int Q_BITS   = 16,
  parameter int ROUND    = 0,
  parameter int SATURATE = 0,
  parameter int IN_W     = 2*D_BITS+2
) (
  input  logic signed [IN_W-1:0]   acc_i,
  output logic        [D_BITS-1:0] res_o,
  output logic                     ovf_o
);

  localparam logic signed [IN_W:0] RND = (ROUND != 0) ? ((IN_W+1)'(1) <<< (Q_BITS-1)) : '0;

  logic signed [IN_W:0]          rounded;
  logic signed [IN_W:0]          shifted;
  logic [IN_W-D_BITS+1:0]        upper;

  assign rounded = {acc_i[IN_W-1], acc_i} + RND;
  assign shifted = rounded >>> Q_BITS;

  // In range exactly when every bit above the result sign bit matches it.
  assign upper = shifted[IN_W:D_BITS-1];
  assign ovf_o = !((&upper) || !(|upper));

  assign res_o = ((SATURATE != 0) && ovf_o)
               ? (shifted[IN_W] ? {1'b1, {(D_BITS-1){1'b0}}} : {1'b0, {(D_BITS-1){1'b1}}})
               : shifted[D_BITS-1:0];

endmodule

// File: rtl/vec3_alu.sv
// rtl/vec3_alu.sv - FIFO-handshaked fixed-point 3-vector ALU (add/sub/dot/cross/scale) on one shared multiplier
module vec3_alu
  import vec_math_pkg::*;
#(
  parameter int D_BITS   = 32,
  parameter int Q_BITS   = 16,
  parameter int ROUND    = 0,
  parameter int SATURATE = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [2:0]             op,
  input  logic [2:0][D_BITS-1:0] x,
  input  logic [2:0][D_BITS-1:0] y,
  input  logic                   in_empty,
  output logic                   in_rd_en,
  output logic [2:0][D_BITS-1:0] out,
  output logic [2:0]             out_ovf,
  output logic                   out_err,
  input  logic                   out_full,
  output logic                   out_wr_en
);

  localparam int ACC_W = 2*D_BITS+2;

  state_t                   state_q, state_d;
  logic [2:0]               step_q, step_d;
  logic [2:0]               op_q;
  logic [2:0][D_BITS-1:0]   x_q, y_q;
  logic signed [ACC_W-1:0]  acc_q [3];
  logic signed [ACC_W-1:0]  acc_d [3];
  logic [2:0][D_BITS-1:0]   out_q, out_d;
  logic [2:0]               ovf_q, ovf_d;
  logic                     err_q, err_d;

  logic                     pop, last_step, load_out;
  logic signed [D_BITS-1:0] mul_a, mul_b;
  logic signed [2*D_BITS-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic [1:0]               lane;
  logic                     neg;
  logic signed [D_BITS:0]   sum [3];
  logic signed [ACC_W-1:0]  conv_in [3];
  logic [2:0][D_BITS-1:0]   conv_res;
  logic [2:0]               conv_ovf;

  assign pop       = !reset && (state_q == IDLE) && !in_empty;
  assign in_rd_en  = pop;
  assign out_wr_en = !reset && (state_q == OUT) && !out_full;
  assign last_step = (state_q == CALC) &&
                     (step_q == ((op_q == OP_CROSS) ? STEPS_CROSS - 3'd1 :
                                 (op_q == OP_DOT)   ? STEPS_DOT - 3'd1 : STEPS_SCALE - 3'd1));

  // Operand routing for the shared multiplier, one product per CALC step.
  always_comb begin
    mul_a = x_q[0];
    mul_b = y_q[0];
    lane  = 2'd0;
    neg   = 1'b0;
    case (op_q)
      OP_DOT: begin
        mul_a = x_q[step_q[1:0]];
        mul_b = y_q[step_q[1:0]];
      end
      OP_SCALE: begin
        mul_a = x_q[step_q[1:0]];
        lane  = step_q[1:0];
      end
      OP_CROSS: begin
        case (step_q)
          3'd0:    begin mul_a = x_q[1]; mul_b = y_q[2]; lane = 2'd0; end
          3'd1:    begin mul_a = x_q[2]; mul_b = y_q[1]; lane = 2'd0; neg = 1'b1; end
          3'd2:    begin mul_a = x_q[2]; mul_b = y_q[0]; lane = 2'd1; end
          3'd3:    begin mul_a = x_q[0]; mul_b = y_q[2]; lane = 2'd1; neg = 1'b1; end
          3'd4:    begin mul_a = x_q[0]; mul_b = y_q[1]; lane = 2'd2; end
          default: begin mul_a = x_q[1]; mul_b = y_q[0]; lane = 2'd2; neg = 1'b1; end
        endcase
      end
      default: ;
    endcase
  end

  assign prod     = mul_a * mul_b;
  assign prod_ext = {{2{prod[2*D_BITS-1]}}, prod};

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      acc_d[i] = acc_q[i];
      if (pop)
        acc_d[i] = '0;
      else if ((state_q == CALC) && (lane == 2'(i)))
        acc_d[i] = acc_q[i] + (neg ? -prod_ext : prod_ext);
    end
  end

  // ADD/SUB are pre-scaled by Q_BITS so the shared converter's shift is exact.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      if (op == OP_SUB)
        sum[i] = {x[i][D_BITS-1], x[i]} - {y[i][D_BITS-1], y[i]};
      else
        sum[i] = {x[i][D_BITS-1], x[i]} + {y[i][D_BITS-1], y[i]};
      conv_in[i] = (state_q == IDLE)
                 ? ({{(ACC_W-D_BITS-1){sum[i][D_BITS]}}, sum[i]} << Q_BITS)
                 : acc_d[i];
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_lane
    vec_round_sat #(
      .D_BITS(D_BITS), .Q_BITS(Q_BITS), .ROUND(ROUND), .SATURATE(SATURATE), .IN_W(ACC_W)
    ) u_conv (
      .acc_i(conv_in[g]),
      .res_o(conv_res[g]),
      .ovf_o(conv_ovf[g])
    );
  end

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    load_out = 1'b0;
    out_d    = conv_res;
    ovf_d    = conv_ovf;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pop) begin
          step_d = 3'd0;
          if (is_product_op(op)) begin
            state_d = CALC;
          end else begin
            state_d  = OUT;
            load_out = 1'b1;
            if (is_illegal_op(op)) begin
              out_d = '0;
              ovf_d = '0;
              err_d = 1'b1;
            end
          end
        end
      end
      CALC: begin
        step_d = step_q + 3'd1;
        if (last_step) begin
          state_d  = OUT;
          load_out = 1'b1;
        end
      end
      OUT: begin
        if (out_wr_en) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      step_q  <= '0;
      op_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      out_q   <= '0;
      ovf_q   <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < 3; i++) acc_q[i] <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      for (int i = 0; i < 3; i++) acc_q[i] <= acc_d[i];
      if (pop) begin
        op_q <= op;
        x_q  <= x;
        y_q  <= y;
      end
      if (load_out) begin
        out_q <= out_d;
        ovf_q <= ovf_d;
        err_q <= err_d;
      end
    end
  end

  assign out     = out_q;
  assign out_ovf = ovf_q;
  assign out_err = err_q;

endmodule

// File: tb/tb_vec3_alu.sv
// tb/tb_vec3_alu.sv - directed self-checking bench for vec3_alu (wrap/truncate and saturate/round instances)
module tb_vec3_alu;

  logic             clock = 1'b0;
  logic             reset;
  logic [2:0]       op_s;
  logic [2:0][31:0] x_s, y_s;
  logic             in_empty, out_full;

  logic [2:0][31:0] out_a, out_b;
  logic [2:0]       ovf_a, ovf_b;
  logic             err_a, err_b, rd_a, rd_b, wr_a, wr_b;

  int checks = 0;
  int failures = 0;
  int lat;

  always #5 clock = ~clock;

  vec3_alu #(.D_BITS(32), .Q_BITS(16), .ROUND(0), .SATURATE(0)) dut (
    .clock(clock), .reset(reset), .op(op_s), .x(x_s), .y(y_s),
    .in_empty(in_empty), .in_rd_en(rd_a), .out(out_a), .out_ovf(ovf_a),
    .out_err(err_a), .out_full(out_full), .out_wr_en(wr_a)
  );

  vec3_alu #(.D_BITS(32), .Q_BITS(16), .ROUND(1), .SATURATE(1)) dut_rs (
    .clock(clock), .reset(reset), .op(op_s), .x(x_s), .y(y_s),
    .in_empty(in_empty), .in_rd_en(rd_b), .out(out_b), .out_ovf(ovf_b),
    .out_err(err_b), .out_full(out_full), .out_wr_en(wr_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0][31:0] v3(input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2);
    return {a2, a1, a0};
  endfunction

  // Presents one transaction, pops it, returns cycles until out_wr_en (bounded at 20).
  task automatic do_txn(input logic [2:0] o, input logic [2:0][31:0] a, input logic [2:0][31:0] b,
                        output int cycles);
    @(negedge clock);
    op_s = o; x_s = a; y_s = b; in_empty = 1'b0;
    #1 check("rd_en_on_pop", {63'd0, rd_a}, 64'd1);
    @(posedge clock);
    cycles = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      cycles++;
      in_empty = 1'b1;
      if (wr_a) break;
    end
  endtask

  initial begin
    reset = 1'b1; in_empty = 1'b0; out_full = 1'b0;
    op_s = '0; x_s = '0; y_s = '0;
    repeat (2) @(negedge clock);
    check("reset_out",  out_a, 96'd0);
    check("reset_ovf",  {61'd0, ovf_a}, 64'd0);
    check("reset_err",  {63'd0, err_a}, 64'd0);
    check("reset_rd",   {63'd0, rd_a}, 64'd0);
    check("reset_wr",   {63'd0, wr_a}, 64'd0);
    in_empty = 1'b1;
    reset = 1'b0;

    do_txn(3'd0, v3(32'h10000, 32'h20000, -32'sh30000), v3(32'h8000, 32'h8000, 32'h8000), lat);
    check("add_lat", lat, 1);
    check("add_out0", out_a[0], 32'h18000);
    check("add_out1", out_a[1], 32'h28000);
    check("add_out2", out_a[2], 32'hFFFD8000);
    check("add_ovf", {61'd0, ovf_a}, 64'd0);
    check("add_err", {63'd0, err_a}, 64'd0);

    do_txn(3'd1, v3(32'h10000, 32'h0, 32'h5), v3(32'h8000, 32'h1, 32'h7), lat);
    check("sub_lat", lat, 1);
    check("sub_out", out_a, {32'hFFFFFFFE, 32'hFFFFFFFF, 32'h8000});

    do_txn(3'd2, v3(32'h10000, 32'h20000, 32'h30000), v3(32'h40000, 32'h50000, 32'h60000), lat);
    check("dot_lat", lat, 4);
    check("dot_out", out_a, {32'h0, 32'h0, 32'h200000});
    check("dot_out_rs", out_b, {32'h0, 32'h0, 32'h200000});
    check("dot_ovf", {61'd0, ovf_a}, 64'd0);

    do_txn(3'd3, v3(32'h10000, 32'h0, 32'h0), v3(32'h0, 32'h10000, 32'h0), lat);
    check("cross_lat", lat, 7);
    check("cross_unit", out_a, {32'h10000, 32'h0, 32'h0});

    do_txn(3'd3, v3(32'h10000, 32'h20000, 32'h30000), v3(32'h40000, 32'h50000, 32'h60000), lat);
    check("cross_lat2", lat, 7);
    check("cross_123x456", out_a, {32'hFFFD0000, 32'h60000, 32'hFFFD0000});

    do_txn(3'd6, v3(32'h11, 32'h22, 32'h33), v3(32'h44, 32'h55, 32'h66), lat);
    check("illegal_lat", lat, 1);
    check("illegal_out", out_a, 96'd0);
    check("illegal_err", {63'd0, err_a}, 64'd1);
    check("illegal_ovf", {61'd0, ovf_a}, 64'd0);

    do_txn(3'd0, v3(32'h7FFFFFFF, 32'h0, 32'h0), v3(32'h1, 32'h0, 32'h0), lat);
    check("addsat_wrap_out0", out_a[0], 32'h80000000);
    check("addsat_wrap_ovf", {61'd0, ovf_a}, 64'd1);
    check("addsat_sat_out0", out_b[0], 32'h7FFFFFFF);
    check("addsat_sat_ovf", {61'd0, ovf_b}, 64'd1);
    check("addsat_err_clear", {63'd0, err_a}, 64'd0);

    do_txn(3'd1, v3(32'h80000000, 32'h0, 32'h0), v3(32'h1, 32'h0, 32'h0), lat);
    check("subsat_wrap_out0", out_a[0], 32'h7FFFFFFF);
    check("subsat_sat_out0", out_b[0], 32'h80000000);
    check("subsat_sat_ovf", {61'd0, ovf_b}, 64'd1);

    do_txn(3'd4, v3(32'h1, 32'hFFFFFFFF, 32'h20000), v3(32'h8000, 32'h0, 32'h0), lat);
    check("scale_lat", lat, 4);
    check("scale_trunc", out_a, {32'h10000, 32'hFFFFFFFF, 32'h0});
    check("scale_round", out_b, {32'h10000, 32'h0, 32'h1});

    do_txn(3'd4, v3(32'h40000000, 32'h0, 32'h0), v3(32'h40000000, 32'h0, 32'h0), lat);
    check("scale_ovf_wrap", out_a[0], 32'h0);
    check("scale_ovf_sat", out_b[0], 32'h7FFFFFFF);
    check("scale_ovf_flag", {61'd0, ovf_a}, 64'd1);

    // Backpressure: DOT finishes while the downstream FIFO is full.
    @(negedge clock);
    out_full = 1'b1; in_empty = 1'b0;
    op_s = 3'd2; x_s = v3(32'h10000, 32'h20000, 32'h30000); y_s = v3(32'h40000, 32'h50000, 32'h60000);
    @(posedge clock);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      op_s = 3'd0; x_s = v3(32'h1, 32'h2, 32'h3); y_s = v3(32'h1, 32'h1, 32'h1);
      #1;
      if (k >= 4) begin
        check("bp_no_wr", {63'd0, wr_a}, 64'd0);
        check("bp_no_rd", {63'd0, rd_a}, 64'd0);
        check("bp_out_stable", out_a[0], 32'h200000);
      end
    end
    out_full = 1'b0;
    #1 check("bp_release_wr", {63'd0, wr_a}, 64'd1);
    @(negedge clock);
    check("bp_next_rd", {63'd0, rd_a}, 64'd1);
    @(negedge clock);
    in_empty = 1'b1;
    check("bp_next_wr", {63'd0, wr_a}, 64'd1);
    check("bp_next_out", out_a, {32'h4, 32'h3, 32'h2});

    // Reset while a CROSS sits at step 3.
    @(negedge clock);
    op_s = 3'd3; x_s = v3(32'h10000, 32'h20000, 32'h30000); y_s = v3(32'h40000, 32'h50000, 32'h60000);
    in_empty = 1'b0;
    @(posedge clock);
    @(negedge clock);
    in_empty = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b1; in_empty = 1'b0;
    #1;
    check("rst_mid_out", out_a, 96'd0);
    check("rst_mid_wr", {63'd0, wr_a}, 64'd0);
    check("rst_mid_rd", {63'd0, rd_a}, 64'd0);
    @(negedge clock);
    in_empty = 1'b1;
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      check("rst_after_no_wr", {63'd0, wr_a}, 64'd0);
    end
    do_txn(3'd3, v3(32'h10000, 32'h0, 32'h0), v3(32'h0, 32'h10000, 32'h0), lat);
    check("rst_next_lat", lat, 7);
    check("rst_next_out", out_a, {32'h10000, 32'h0, 32'h0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vec3_alu.md
Name: vec3_alu

Overview:
- Multi-op fixed-point 3-vector arithmetic unit that replaces the separate add/dot/cross/scale units with one FIFO-handshaked block.
- Selects ADD, SUB, DOT, CROSS or SCALE per transaction through an op field carried with the operands.
- Time-shares a single signed D_BITS x D_BITS multiplier and adds configurable rounding and saturation.
- Reads from an upstream FIFO (in_empty/in_rd_en) and writes to a downstream FIFO (out_full/out_wr_en) inside the ray–triangle pipeline.

Parameters:
- D_BITS, 32: operand and result width, signed two's complement.
- Q_BITS, 16: fractional bits; legal range 1..D_BITS-1.
- ROUND, 0: 1 = round-half-up (add 1<<(Q_BITS-1) before the shift); 0 = truncate (arithmetic shift toward -inf).
- SATURATE, 0: 1 = clamp results to the D_BITS signed range; 0 = wrap (keep low D_BITS).

Ports:
- clock  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- op  in  3  operation: 0 ADD, 1 SUB, 2 DOT, 3 CROSS, 4 SCALE, 5-7 illegal.
- x  in  D_BITS x3  operand vector A.
- y  in  D_BITS x3  operand vector B; y[0] is the scalar for SCALE.
- in_empty  in  1  upstream FIFO empty.
- in_rd_en  out  1  upstream pop; combinational.
- out  out  D_BITS x3  result vector; registered.
- out_ovf  out  3  per-lane overflow (clamped or wrapped); registered.
- out_err  out  1  illegal op flag; registered.
- out_full  in  1  downstream FIFO full.
- out_wr_en  out  1  downstream push; combinational.

Behaviour:
- Reset (asynchronous): state IDLE, step counter 0, accumulators 0, out = 0, out_ovf = 0, out_err = 0. Any in-flight transaction is discarded with no partial write. in_rd_en and out_wr_en are 0 while reset is asserted.
- State IDLE:
  - If !in_empty: in_rd_en = 1 for one cycle, and op, x and y are latched.
  - ADD/SUB/illegal ops go to OUT.
  - DOT/CROSS/SCALE go to CALC with step = 0.
  - in_empty is sampled only in IDLE; the block holds at most one transaction.
- State CALC: one product per cycle from the shared multiplier, accumulated at full 2*D_BITS+2 width. Product order:
  - DOT, 3 steps: x0y0, x1y1, x2y2 into acc0.
  - SCALE, 3 steps: x_i*y0 into acc_i.
  - CROSS, 6 steps:
    - acc0 = +x1y2, then -x2y1
    - acc1 = +x2y0, then -x0y2
    - acc2 = +x0y1, then -x1y0
  - On the last step the block applies round, shift and saturate, registers out/out_ovf, and goes to OUT.
- State OUT: out_wr_en = !out_full. When out_wr_en is 1, go to IDLE. out, out_ovf and out_err stay stable for the whole time the block waits in OUT.
- Latency, with in_rd_en at cycle t and out_full = 0:
  - ADD/SUB: out_wr_en at t+1.
  - DOT/SCALE: out_wr_en at t+4.
  - CROSS: out_wr_en at t+7.
- Throughput: the next in_rd_en comes no earlier than the cycle after out_wr_en.
- ADD/SUB arithmetic: computed at D_BITS+1 width, then saturated or wrapped. No shift is applied.
- Product ops:
  - result = (acc [+ round term]) >>> Q_BITS, then saturated or wrapped to D_BITS.
  - CROSS differences are formed before the shift.
  - out_ovf[i] = 1 when the pre-limit value is outside [-2^(D_BITS-1), 2^(D_BITS-1)-1], regardless of SATURATE.
- DOT output: result in out[0]; out[1] and out[2] are 0 with ovf 0.
- Illegal op: the operands are consumed, out = 0, out_err = 1, written through the normal OUT state. out_err is 0 for all legal ops.

Decomposition:
- Package vec_math_pkg holds:
  - the op_t enum (OP_ADD..OP_SCALE);
  - the state_t enum (IDLE, CALC, OUT);
  - the step-count constants: DOT 3, SCALE 3, CROSS 6.
- Sub-module vec_round_sat: combinational wide-accumulator to D_BITS converter (round, shift, clamp/wrap, ovf). Parameters: D_BITS, Q_BITS, ROUND, SATURATE, IN_W. It is instantiated three times, once per lane.

Test Plan (D_BITS=32, Q_BITS=16 unless noted):
- ADD: x=(0x10000, 0x20000, -0x30000), y=(0x8000, 0x8000, 0x8000) -> out=(0x18000, 0x28000, -0x28000), ovf=0, out_wr_en at t+1.
- DOT: x=(1.0, 2.0, 3.0), y=(4.0, 5.0, 6.0) -> out[0]=0x200000, out[1]=out[2]=0, out_wr_en at t+4.
- CROSS:
  - x=(1.0, 0, 0), y=(0, 1.0, 0) -> out=(0, 0, 0x10000), out_wr_en at t+7.
  - Then op=6 -> out=0, out_err=1.
- SAT, SATURATE=1: ADD with x0=0x7FFFFFFF, y0=1 -> out[0]=0x7FFFFFFF, ovf=3'b001. With SATURATE=0 -> out[0]=0x80000000, ovf=3'b001.
- ROUND: SCALE with x0=1, y0=0x8000 -> out[0]=1 when ROUND=1, 0 when ROUND=0.
- Backpressure and reset:
  - Hold out_full=1 for 5 cycles after a DOT completes -> out stable, in_rd_en=0, single out_wr_en on the first cycle out_full=0.
  - Assert reset at CROSS step 3 -> out=0, no write, next transaction is correct.
